// File: rtl/nv_nvdla_pdp_pipe_pkg.sv
// Shared constants and helpers for the PDP valid/ready pipeline.
// Imported by the pipe interface, stage and top.
package nv_nvdla_pdp_pipe_pkg;

  localparam int STAGES_MAX = 4;
  localparam int WIDTH_MAX  = 1024;

  // Ceiling log2; callers always pass at least 2, so the result is never zero.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/nv_nvdla_pdp_pipe_skid_if.sv
// Valid/ready/payload bundle for the PDP pipe.
// The producer side uses master and the consumer side uses slave.
interface nv_nvdla_pdp_pipe_skid_if #(
  parameter int WIDTH = 185
);

  logic             vld;
  logic             rdy;
  logic [WIDTH-1:0] pd;

  modport master (output vld, output pd, input rdy);
  modport slave  (input vld, input pd, output rdy);

endinterface

// File: rtl/nv_nvdla_pdp_pipe_stage.sv
// One bubble-collapsing valid/ready register stage.
// An empty stage accepts data even while the stage downstream is stalled.
module nv_nvdla_pdp_pipe_stage
  import nv_nvdla_pdp_pipe_pkg::*;
#(
  parameter int WIDTH = 185
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             vld_in,
  output logic             rdy_out,
  input  logic [WIDTH-1:0] pd_in,
  output logic             vld,
  input  logic             rdy_in,
  output logic [WIDTH-1:0] pd
);

  assign rdy_out = rdy_in | ~vld;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      vld <= 1'b0;
    end else if (rdy_out) begin
      vld <= vld_in;
    end
  end

  // Payload flops carry no reset; they only matter while vld is set.
  always_ff @(posedge nvdla_core_clk) begin
    if (rdy_out & vld_in) begin
      pd <= pd_in;
    end
  end

endmodule

// File: rtl/nv_nvdla_pdp_pipe_skid.sv
// Parametrised PDP pipe: STAGES bubble-collapsing stages, plus an optional
// one-entry input skid that makes in_rdy come straight from a flop.
module nv_nvdla_pdp_pipe_skid
  import nv_nvdla_pdp_pipe_pkg::*;
#(
  parameter  int WIDTH  = 185,
  parameter  int STAGES = 2,
  parameter  int SKID   = 0,
  localparam int OCC_W  = clog2(STAGES + SKID + 1)
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  nv_nvdla_pdp_pipe_skid_if.slave  in_if,
  nv_nvdla_pdp_pipe_skid_if.master out_if,
  output logic [OCC_W-1:0]         occ
);

  logic             stg_vld_in  [STAGES];
  logic             stg_rdy_out [STAGES];
  logic [WIDTH-1:0] stg_pd_in   [STAGES];
  logic             stg_vld     [STAGES];
  logic             stg_rdy_in  [STAGES];
  logic [WIDTH-1:0] stg_pd      [STAGES];
  logic             skid_full;

  if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("nv_nvdla_pdp_pipe_skid: STAGES out of range");
  end
  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("nv_nvdla_pdp_pipe_skid: WIDTH out of range");
  end
  if (SKID != 0 && SKID != 1) begin : g_bad_skid
    $error("nv_nvdla_pdp_pipe_skid: SKID must be 0 or 1");
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign stg_vld_in[k] = stg_vld[k-1];
      assign stg_pd_in[k]  = stg_pd[k-1];
    end
    if (k < STAGES - 1) begin : g_mid
      assign stg_rdy_in[k] = stg_rdy_out[k+1];
    end else begin : g_last
      assign stg_rdy_in[k] = out_if.rdy;
    end

    nv_nvdla_pdp_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .vld_in          (stg_vld_in[k]),
      .rdy_out         (stg_rdy_out[k]),
      .pd_in           (stg_pd_in[k]),
      .vld             (stg_vld[k]),
      .rdy_in          (stg_rdy_in[k]),
      .pd              (stg_pd[k])
    );
  end

  assign out_if.vld = stg_vld[STAGES-1];
  assign out_if.pd  = stg_pd[STAGES-1];

  if (SKID != 0) begin : g_skid
    logic             in_rdy_q;
    logic [WIDTH-1:0] skid_pd;
    logic             skid_push;
    logic             skid_pop;
    logic             skid_full_next;

    // A held skid entry always goes to stage 1 ahead of anything new,
    // so an accepted beat lands in the skid whenever stage 1 is busy with it.
    assign skid_push      = in_if.vld & in_rdy_q & (skid_full | ~stg_rdy_out[0]);
    assign skid_pop       = skid_full & stg_rdy_out[0];
    assign skid_full_next = skid_push | (skid_full & ~skid_pop);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
        skid_full <= 1'b0;
        in_rdy_q  <= 1'b1;
      end else begin
        skid_full <= skid_full_next;
        in_rdy_q  <= ~skid_full_next;
      end
    end

    always_ff @(posedge nvdla_core_clk) begin
      if (skid_push) begin
        skid_pd <= in_if.pd;
      end
    end

    assign in_if.rdy     = in_rdy_q;
    assign stg_vld_in[0] = skid_full | in_if.vld;
    assign stg_pd_in[0]  = skid_full ? skid_pd : in_if.pd;
  end else begin : g_no_skid
    assign skid_full     = 1'b0;
    assign in_if.rdy     = stg_rdy_out[0];
    assign stg_vld_in[0] = in_if.vld;
    assign stg_pd_in[0]  = in_if.pd;
  end

  // Occupancy is a sum of flop outputs, so it clears with the async reset.
  always_comb begin
    occ = OCC_W'(skid_full);
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + OCC_W'(stg_vld[k]);
    end
  end

endmodule

// File: tb/tb_nv_nvdla_pdp_pipe_skid.sv
// Bench for nv_nvdla_pdp_pipe_skid: three configurations side by side,
// directed vector tables, a reset-mid-stream sequence and a random scoreboard run.
module tb_nv_nvdla_pdp_pipe_skid;
  import nv_nvdla_pdp_pipe_pkg::*;

  localparam int W  = 16;
  localparam int NI = 3;
  localparam int ST [NI] = '{3, 2, 2};
  localparam int SK [NI] = '{0, 0, 1};

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic         in_vld      [NI];
  logic         out_rdy     [NI];
  logic [W-1:0] in_pd       [NI];
  logic         obs_in_rdy  [NI];
  logic         obs_out_vld [NI];
  logic [W-1:0] obs_out_pd  [NI];
  logic [2:0]   obs_occ     [NI];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int MAXOCC = ST[g] + SK[g];
    localparam int OW     = clog2(MAXOCC + 1);

    nv_nvdla_pdp_pipe_skid_if #(.WIDTH(W)) if_up ();
    nv_nvdla_pdp_pipe_skid_if #(.WIDTH(W)) if_dn ();
    logic [OW-1:0] occ_l;

    assign if_up.vld       = in_vld[g];
    assign if_up.pd        = in_pd[g];
    assign if_dn.rdy       = out_rdy[g];
    assign obs_in_rdy[g]   = if_up.rdy;
    assign obs_out_vld[g]  = if_dn.vld;
    assign obs_out_pd[g]   = if_dn.pd;
    assign obs_occ[g]      = 3'(occ_l);

    nv_nvdla_pdp_pipe_skid #(
      .WIDTH  (W),
      .STAGES (ST[g]),
      .SKID   (SK[g])
    ) u_dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .in_if           (if_up),
      .out_if          (if_dn),
      .occ             (occ_l)
    );

    // Scoreboard: FIFO order, occupancy equals beats in flight, hold under stall.
    logic [W-1:0] q [$];
    logic         hold_v = 1'b0;
    logic [W-1:0] hold_pd;
    logic [W-1:0] exp_pd;
    always @(negedge clk) begin
      if (!rstn) begin
        q.delete();
        hold_v = 1'b0;
      end else begin
        check($sformatf("u%0d occ_vs_model", g), 32'(obs_occ[g]), 32'(q.size()));
        check($sformatf("u%0d occ_bound", g), 32'(obs_occ[g] <= 3'(MAXOCC)), 32'd1);
        if (hold_v) begin
          check($sformatf("u%0d hold_vld", g), 32'(obs_out_vld[g]), 32'd1);
          check($sformatf("u%0d hold_pd", g), 32'(obs_out_pd[g]), 32'(hold_pd));
        end
        if (obs_out_vld[g] && out_rdy[g]) begin
          exp_pd = (q.size() != 0) ? q.pop_front() : 'x;
          check($sformatf("u%0d order", g), 32'(obs_out_pd[g]), 32'(exp_pd));
        end
        if (in_vld[g] && obs_in_rdy[g]) begin
          q.push_back(in_pd[g]);
        end
        hold_v  = obs_out_vld[g] && !out_rdy[g];
        hold_pd = obs_out_pd[g];
      end
    end
  end

  typedef struct {
    int           inst;
    logic         vld;
    logic [W-1:0] pd;
    logic         ordy;
    logic         e_rdy;
    logic         e_ovld;
    logic [W-1:0] e_pd;
    int           e_occ;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input int inst, input logic vld, input logic [W-1:0] pd, input logic ordy,
                     input logic e_rdy, input logic e_ovld, input logic [W-1:0] e_pd, input int e_occ);
    vec_t v;
    v.inst = inst; v.vld = vld; v.pd = pd; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ovld = e_ovld; v.e_pd = e_pd; v.e_occ = e_occ;
    tbl.push_back(v);
  endtask

  logic         acc   [NI];
  logic [W-1:0] cnt   [NI];
  int           n_in  [NI];
  int           n_out [NI];

  initial begin
    rstn = 1'b0;
    for (int g = 0; g < NI; g++) begin
      in_vld[g] = 1'b0; out_rdy[g] = 1'b0; in_pd[g] = '0;
      acc[g] = 1'b0; cnt[g] = 16'h1000 * W'(g + 1); n_in[g] = 0; n_out[g] = 0;
    end

    // Row: inst, in_vld, in_pd, out_rdy | in_rdy, out_vld, out_pd, occ (after this cycle's edge)
    // Streaming, STAGES=3: first beat visible three cycles after its handshake
    add(0,1,'h01,1, 1,0,'h00,0);  add(0,1,'h02,1, 1,0,'h00,1);
    add(0,1,'h03,1, 1,0,'h00,2);  add(0,1,'h04,1, 1,1,'h01,3);
    add(0,1,'h05,1, 1,1,'h02,3);  add(0,1,'h06,1, 1,1,'h03,3);
    add(0,1,'h07,1, 1,1,'h04,3);  add(0,1,'h08,1, 1,1,'h05,3);
    add(0,0,'h00,1, 1,1,'h06,3);  add(0,0,'h00,1, 1,1,'h07,2);
    add(0,0,'h00,1, 1,1,'h08,1);  add(0,0,'h00,1, 1,0,'h00,0);
    // Bubble collapse, STAGES=3, out_rdy low, beats 3 cycles apart
    add(0,1,'h11,0, 1,0,'h00,0);  add(0,0,'h11,0, 1,0,'h00,1);
    add(0,0,'h11,0, 1,0,'h00,1);  add(0,1,'h12,0, 1,1,'h11,1);
    add(0,0,'h12,0, 1,1,'h11,2);  add(0,0,'h12,0, 1,1,'h11,2);
    add(0,1,'h13,0, 1,1,'h11,2);  add(0,0,'h13,0, 0,1,'h11,3);
    add(0,0,'h13,0, 0,1,'h11,3);  add(0,0,'h13,1, 1,1,'h11,3);
    add(0,0,'h13,1, 1,1,'h12,2);  add(0,0,'h13,1, 1,1,'h13,1);
    add(0,0,'h13,1, 1,0,'h00,0);
    // Backpressure, STAGES=2, SKID=0: out_rdy low for 5 cycles
    add(1,1,'h21,1, 1,0,'h00,0);  add(1,1,'h22,1, 1,0,'h00,1);
    add(1,1,'h23,0, 0,1,'h21,2);  add(1,1,'h23,0, 0,1,'h21,2);
    add(1,1,'h23,0, 0,1,'h21,2);  add(1,1,'h23,0, 0,1,'h21,2);
    add(1,1,'h23,0, 0,1,'h21,2);  add(1,1,'h23,1, 1,1,'h21,2);
    add(1,1,'h24,1, 1,1,'h22,2);  add(1,0,'h00,1, 1,1,'h23,2);
    add(1,0,'h00,1, 1,1,'h24,1);  add(1,0,'h00,1, 1,0,'h00,0);
    // Skid, STAGES=2, SKID=1: one extra beat absorbed, in_rdy falls a cycle late
    add(2,1,'h31,1, 1,0,'h00,0);  add(2,1,'h32,1, 1,0,'h00,1);
    add(2,1,'h33,0, 1,1,'h31,2);  add(2,1,'h34,0, 0,1,'h31,3);
    add(2,1,'h34,0, 0,1,'h31,3);  add(2,1,'h34,1, 0,1,'h31,3);
    add(2,1,'h34,1, 1,1,'h32,2);  add(2,0,'h00,1, 1,1,'h33,2);
    add(2,0,'h00,1, 1,1,'h34,1);  add(2,0,'h00,1, 1,0,'h00,0);

    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("u%0d reset_out_vld", g), 32'(obs_out_vld[g]), 32'd0);
      check($sformatf("u%0d reset_occ", g), 32'(obs_occ[g]), 32'd0);
      check($sformatf("u%0d reset_in_rdy", g), 32'(obs_in_rdy[g]), 32'd1);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      in_vld[tbl[i].inst]  = tbl[i].vld;
      in_pd[tbl[i].inst]   = tbl[i].pd;
      out_rdy[tbl[i].inst] = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("vec%0d in_rdy", i), 32'(obs_in_rdy[tbl[i].inst]), 32'(tbl[i].e_rdy));
      check($sformatf("vec%0d out_vld", i), 32'(obs_out_vld[tbl[i].inst]), 32'(tbl[i].e_ovld));
      check($sformatf("vec%0d occ", i), 32'(obs_occ[tbl[i].inst]), 32'(tbl[i].e_occ));
      if (tbl[i].e_ovld) begin
        check($sformatf("vec%0d out_pd", i), 32'(obs_out_pd[tbl[i].inst]), 32'(tbl[i].e_pd));
      end
    end

    // Asynchronous reset with both STAGES=2 pipes full and stalled
    @(posedge clk); #1;
    in_vld[1] = 1'b1; in_pd[1] = 'h41; out_rdy[1] = 1'b0;
    in_vld[2] = 1'b1; in_pd[2] = 'h51; out_rdy[2] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("u1 prereset_occ", 32'(obs_occ[1]), 32'd2);
    check("u2 prereset_occ", 32'(obs_occ[2]), 32'd3);
    #1 rstn = 1'b0;
    #1;
    for (int g = 1; g < NI; g++) begin
      check($sformatf("u%0d async_out_vld", g), 32'(obs_out_vld[g]), 32'd0);
      check($sformatf("u%0d async_occ", g), 32'(obs_occ[g]), 32'd0);
    end
    in_vld[1] = 1'b0; in_vld[2] = 1'b0;
    @(negedge clk);
    @(posedge clk); #3 rstn = 1'b1;
    @(negedge clk);
    for (int g = 1; g < NI; g++) begin
      check($sformatf("u%0d release_in_rdy", g), 32'(obs_in_rdy[g]), 32'd1);
      check($sformatf("u%0d release_out_vld", g), 32'(obs_out_vld[g]), 32'd0);
    end

    // Random traffic; the scoreboards check every cycle
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NI; g++) begin
        if (!in_vld[g] || acc[g]) begin
          in_vld[g] = ($urandom_range(0, 3) != 0);
          in_pd[g]  = cnt[g];
          cnt[g]    = cnt[g] + 1'b1;
        end
        out_rdy[g] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int g = 0; g < NI; g++) acc[g] = in_vld[g] && obs_in_rdy[g];
    end

    // Continuous valid and ready must give one beat per cycle each way
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NI; g++) begin
        if (!in_vld[g] || acc[g]) begin
          in_pd[g] = cnt[g];
          cnt[g]   = cnt[g] + 1'b1;
        end
        in_vld[g]  = 1'b1;
        out_rdy[g] = 1'b1;
      end
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        acc[g] = in_vld[g] && obs_in_rdy[g];
        if (c >= 10) begin
          if (acc[g]) n_in[g]++;
          if (obs_out_vld[g]) n_out[g]++;
        end
      end
    end
    for (int g = 0; g < NI; g++) begin
      check($sformatf("u%0d thru_in", g), 32'(n_in[g]), 32'd10);
      check($sformatf("u%0d thru_out", g), 32'(n_out[g]), 32'd10);
    end

    @(posedge clk); #1;
    for (int g = 0; g < NI; g++) in_vld[g] = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("u%0d drained_occ", g), 32'(obs_occ[g]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
